regfile_bank: RTL and testbench

Architectural integer register file for the 32-bit RISC-V core: 32 × 32-bit registers, two combinational read ports, one synchronous write port, x0 hard-wired to zero. Write select is a 5→32 one-hot decode qualified by write enable. Each read port gates every register word with its one-hot read select and OR-reduces the gated words. Sits between decode (rs1/rs2/rd addresses) and the ALU operand path; writeback drives the write port.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/decoder5to32.sv | 21 ++
 rtl/regfile_bank.sv | 85 ++++++++
 tb/tb_regfile_bank.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file parameters for decode, forwarding and the register bank.
package regfile_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    localparam logic [AW-1:0]   ZERO_REG  = 5'd0;
    localparam logic [XLEN-1:0] RESET_VAL = 32'h0;

endpackage : regfile_pkg

// File: rtl/decoder5to32.sv
// 5-bit address to 32-bit one-hot decoder with enable.
// Ports:
//   addr     - register address
//   en       - when low, every select bit is 0
//   onehot_c - combinational one-hot select
module decoder5to32
    import regfile_pkg::*;
(
    input  logic [AW-1:0]   addr,
    input  logic            en,
    output logic [NREG-1:0] onehot_c
);

    always_comb begin
        onehot_c = '0;
        if (en) begin
            onehot_c[addr] = 1'b1;
        end
    end

endmodule : decoder5to32

// File: rtl/regfile_bank.sv
// Architectural integer register file: 32 x 32-bit, x0 reads as zero,
// two combinational read ports, one synchronous write port.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   we/waddr/wdata  - writeback port
//   raddr1, raddr2  - rs1 / rs2 addresses
//   rdata1, rdata2  - combinational operands
module regfile_bank
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    // x1..x31 only; x0 has no storage
    logic [XLEN-1:0] regs [1:NREG-1];

    logic [NREG-1:0] wsel_c;
    logic [NREG-1:0] rsel1_c;
    logic [NREG-1:0] rsel2_c;
    logic [XLEN-1:0] stored1_c;
    logic [XLEN-1:0] stored2_c;

    decoder5to32 u_wdec  (.addr(waddr),  .en(we),   .onehot_c(wsel_c));
    decoder5to32 u_rdec1 (.addr(raddr1), .en(1'b1), .onehot_c(rsel1_c));
    decoder5to32 u_rdec2 (.addr(raddr2), .en(1'b1), .onehot_c(rsel2_c));

    // Bit 0 of every select belongs to x0, which is never loaded or read
    logic unused_sel_x0;
    assign unused_sel_x0 = wsel_c[0] ^ rsel1_c[0] ^ rsel2_c[0];

    // Storage: reset wins over any write in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (wsel_c[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // AND-gate each word with its select bit, OR-reduce across registers
    always_comb begin
        stored1_c = RESET_VAL;
        stored2_c = RESET_VAL;
        for (int unsigned i = 1; i < NREG; i++) begin
            stored1_c = stored1_c | (regs[i] & {XLEN{rsel1_c[i]}});
            stored2_c = stored2_c | (regs[i] & {XLEN{rsel2_c[i]}});
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Write-through forwarding; never for x0 and never during reset
    logic fwd_ok_c;
    assign fwd_ok_c = we && rst_n && (waddr != ZERO_REG);

    always_comb begin
        rdata1 = stored1_c;
        rdata2 = stored2_c;
        if (fwd_ok_c && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end
        if (fwd_ok_c && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end
    end
`else
    assign rdata1 = stored1_c;
    assign rdata2 = stored2_c;
`endif

endmodule : regfile_bank

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank: directed vector table plus sweeps.
module tb_regfile_bank;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_bank dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr1;
        logic [4:0]  raddr2;
        logic        chk;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vec [NVEC];

    function automatic vec_t mk(logic r, logic w, logic [4:0] wa, logic [31:0] wd,
                                logic [4:0] a1, logic [4:0] a2, logic c,
                                logic [31:0] e1, logic [31:0] e2);
        vec_t v;
        v.rst_n = r; v.we = w; v.waddr = wa; v.wdata = wd;
        v.raddr1 = a1; v.raddr2 = a2; v.chk = c; v.exp1 = e1; v.exp2 = e2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, settle, leave the rising edge to commit
    task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        rst_n = r; we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;

        vec[0]  = mk(1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd0,  5'd0,  1'b0, 32'h0, 32'h0);
        // Reset with in-flight write: stored value read, bypass suppressed
        vec[1]  = mk(1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd31, 1'b1, 32'h0, 32'h0);
        vec[2]  = mk(1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  1'b1,
                     BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0);
        vec[3]  = mk(1'b1, 1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF);
        // Write to x0 is a no-op and is never forwarded
        vec[4]  = mk(1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  1'b1, 32'h0, 32'hDEADBEEF);
        vec[5]  = mk(1'b1, 1'b0, 5'd0,  32'h0,        5'd0,  5'd6,  1'b1, 32'h0, 32'h0);
        vec[6]  = mk(1'b1, 1'b1, 5'd7,  32'h00001234, 5'd5,  5'd7,  1'b1,
                     32'hDEADBEEF, BYP ? 32'h00001234 : 32'h0);
        vec[7]  = mk(1'b1, 1'b1, 5'd7,  32'h0000ABCD, 5'd7,  5'd7,  1'b1,
                     BYP ? 32'h0000ABCD : 32'h00001234, BYP ? 32'h0000ABCD : 32'h00001234);
        vec[8]  = mk(1'b1, 1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  1'b1, 32'h0000ABCD, 32'h0000ABCD);
        vec[9]  = mk(1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd7,  1'b1, 32'h0, 32'h0000ABCD);
        vec[10] = mk(1'b1, 1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  1'b1, 32'h0, 32'h0);

        for (int k = 0; k < NVEC; k++) begin
            drive(vec[k].rst_n, vec[k].we, vec[k].waddr, vec[k].wdata, vec[k].raddr1, vec[k].raddr2);
            if (vec[k].chk) begin
                check($sformatf("vec%0d_rdata1", k), rdata1, vec[k].exp1);
                check($sformatf("vec%0d_rdata2", k), rdata2, vec[k].exp2);
            end
        end

        // After reset every address reads zero on both ports
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            check($sformatf("zero_p1_x%0d", a), rdata1, 32'h0);
            check($sformatf("zero_p2_x%0d", 31 - a), rdata2, 32'h0);
        end

        // Single write to x5 must not disturb any other register
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(a));
            check($sformatf("x5only_p1_x%0d", a), rdata1, (a == 5) ? 32'hDEADBEEF : 32'h0);
            check($sformatf("x5only_p2_x%0d", a), rdata2, (a == 5) ? 32'hDEADBEEF : 32'h0);
        end

        // Distinct patterns, then opposite-direction sweeps on the two ports
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
        end
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            check($sformatf("pat_p1_x%0d", a), rdata1, 32'(a) * 32'h01010101);
            check($sformatf("pat_p2_x%0d", 31 - a), rdata2, 32'(31 - a) * 32'h01010101);
        end

        // Reset clears the whole bank
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
        check("post_reset_x1", rdata1, 32'h0);
        check("post_reset_x31", rdata2, 32'h0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_regfile_bank
